baud_controller: RTL
====================

// Module: baud_controller
// PURPOSE
//  Schedules the shared UART bit-timing resource for the transmitter and receiver.
//  Derives independent tx and rx tick streams from one clock, with a runtime-selectable divisor.
//  A config handshake changes the divisor only while both serial engines are idle.
//  Sits between the host-side command decoder and the uart_tx/uart_rx engines.
// PARAMETERS
//  SCALE  28  clock cycles per bit at div=0 (115200 baud)
//  CNTW   8   bit-counter width; 6*SCALE-1 must fit in CNTW bits
// PORTS
//  clock        in   1  system clock, all logic on posedge
//  reset        in   1  asynchronous, active-low: reset=0 forces reset state immediately
//  cfg_valid    in   1  divisor change request
//  cfg_div      in   2  requested divisor code: 00=x1, 01=x2, 10=x3, 11=x6 SCALE
//  cfg_ready    out  1  controller can accept a request
//  cfg_pending  out  1  request accepted but not yet applied
//  cur_div      out  2  divisor code currently in force
//  tx_busy      in   1  transmitter is mid-frame
//  tx_tick      out  1  one-cycle pulse per tx bit period
//  rx_sync      in   1  one-cycle pulse on start-bit detection; re-phases rx timing
//  rx_busy      in   1  receiver is mid-frame
//  rx_tick      out  1  one-cycle pulse at rx bit centres
// BEHAVIOUR
//  - Period P = SCALE*M, where M={1,2,3,6}[cur_div]; compare against 32-bit constants, then truncate to CNTW.
//  - Reset values: cur_div=00, tx_tick=0, rx_tick=0, cfg_ready=1, cfg_pending=0.
//    Both counters are 0 and the FSM is IDLE. Any pending request is discarded.
//  - TX timer:
//    - While tx_busy=0: counter held at 0, tx_tick=0.
//    - While tx_busy=1: counter increments. At P-1 it wraps to 0 and tx_tick (registered) is high the next cycle.
//    - The first tick comes exactly P cycles after the first cycle tx_busy is sampled high.
//  - RX timer:
//    - rx_sync=1 clears the counter and arms the half-period target (P/2 floor)-1. rx_sync wins over everything else.
//    - After the half-period tick the target becomes P-1.
//    - The first rx_tick comes P/2 cycles after the rx_sync cycle; later ticks are P apart while rx_busy=1.
//    - rx_busy=0 with no rx_sync: counter held at 0, no tick.
//    - rx_sync mid-frame re-phases the timer the same way.
//  - TX and RX are independent: both ticks may assert in the same cycle.
//  - Config FSM (3 states):
//    - IDLE: cfg_ready=1. A transfer happens when cfg_valid&cfg_ready.
//      On transfer, latch cfg_div into pend_div and drop cfg_ready.
//      Next state is PENDING if tx_busy|rx_busy|rx_sync is sampled that cycle, else APPLY.
//    - PENDING: cfg_ready=0, cfg_pending=1. Go to APPLY on the first cycle with tx_busy=0, rx_busy=0, rx_sync=0.
//    - APPLY (1 cycle): cur_div<=pend_div, both counters cleared, cfg_pending=1. Go to IDLE, where cfg_ready=1 next cycle.
//  - cfg_valid while cfg_ready=0 is ignored; the requester holds the request until it transfers.
//  - cur_div never changes mid-frame: no tick period is ever mixed across divisors.
//  - A request equal to cur_div still passes through APPLY; ticks are unaffected.
//  - Busy rising in the same cycle as acceptance goes to PENDING. That frame runs at the old P.
//  - reset asserted in any state returns everything to the reset values on the next edge-free evaluation.
// STRUCTURE
//  - Shared include baud_defs.vh holds:
//    - DIV_115200/57600/38400/19200 codes
//    - M multipliers
//    - FSM state encodings ST_IDLE/ST_PENDING/ST_APPLY
//  - Sub-module bit_timer (clear, enable, target, tick out) is instantiated once for tx and once for rx.
//  - The FSM and divisor mux live in the top.
// TESTING (SCALE=28)
//  - Release reset: cur_div=00, cfg_ready=1, cfg_pending=0, no ticks for 500 cycles with busy low.
//  - div=00, tx_busy=1 for 300 cycles: tx_tick at cycles 28, 56, ... Drop busy: no further ticks; re-raise gives first tick at +28.
//  - Set div=01, pulse rx_sync, then rx_busy=1: rx_tick at +28, +84, +140 after sync.
//  - tx_busy=1, request div=11: cfg_ready=0, cfg_pending=1, ticks stay 28 apart.
//    Drop busy: cur_div=11 two cycles later, cfg_ready=1. Next frame ticks 168 apart.
//  - reset=0 while PENDING: cur_div=00, cfg_ready=1, cfg_pending=0, no APPLY after release.
//  - rx_sync at cycle 40 of an rx frame (div=00): next rx_tick at sync+14, then every 28. A simultaneous tx_tick is unaffected.

Source files
------------

// File: rtl/baud_controller_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : baud_controller_pkg
//  Brief    : Divisor codes, bit-period multipliers and config FSM states
//             shared by the baud controller and its bit timers.
//  Revision : 1.0 - initial release
// ============================================================================
package baud_controller_pkg;

  // Divisor codes as seen on cfg_div / cur_div
  localparam logic [1:0] DIV_115200 = 2'b00;
  localparam logic [1:0] DIV_57600  = 2'b01;
  localparam logic [1:0] DIV_38400  = 2'b10;
  localparam logic [1:0] DIV_19200  = 2'b11;

  // Bit-period multipliers applied to SCALE for each divisor code
  localparam int unsigned M_115200 = 1;
  localparam int unsigned M_57600  = 2;
  localparam int unsigned M_38400  = 3;
  localparam int unsigned M_19200  = 6;

  // Config handshake states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_APPLY   = 2'd2
  } state_t;

  // Multiplier for a divisor code
  function automatic int unsigned div_mult(input logic [1:0] div);
    int unsigned m;
    m = M_115200;
    case (div)
      DIV_115200: m = M_115200;
      DIV_57600:  m = M_57600;
      DIV_38400:  m = M_38400;
      DIV_19200:  m = M_19200;
      default:    m = M_115200;
    endcase
    return m;
  endfunction

endpackage : baud_controller_pkg
`default_nettype wire

// File: rtl/baud_controller_bit_timer.sv
`default_nettype none
// ============================================================================
//  Module   : baud_controller_bit_timer
//  Brief    : Free-running bit counter that wraps at a runtime target and
//             emits a registered one-cycle tick on each wrap.
//  Revision : 1.0 - initial release
// ============================================================================
module baud_controller_bit_timer #(
  parameter int CNTW = 8
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            clear,
  input  logic            start,
  input  logic            enable,
  input  logic [CNTW-1:0] target,
  output logic            tick
);

  logic [CNTW-1:0] r_cnt;

  // Count while enabled; 'start' re-phases so the start cycle itself is count
  // zero, giving the same latency convention as an enable rising from idle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
      tick  <= 1'b0;
    end else if (start) begin
      r_cnt <= CNTW'(1);
      tick  <= 1'b0;
    end else if (clear || !enable) begin
      r_cnt <= '0;
      tick  <= 1'b0;
    end else if (r_cnt == target) begin
      r_cnt <= '0;
      tick  <= 1'b1;
    end else begin
      r_cnt <= r_cnt + CNTW'(1);
      tick  <= 1'b0;
    end
  end

endmodule : baud_controller_bit_timer
`default_nettype wire

// File: rtl/baud_controller.sv
`default_nettype none
// ============================================================================
//  Module   : baud_controller
//  Brief    : Shared UART bit-timing resource. Produces independent tx and rx
//             tick streams and swaps the divisor only while both serial
//             engines are idle, through a ready/pending config handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module baud_controller #(
  parameter int SCALE = 28,
  parameter int CNTW  = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cfg_valid,
  input  logic [1:0] cfg_div,
  output logic       cfg_ready,
  output logic       cfg_pending,
  output logic [1:0] cur_div,
  input  logic       tx_busy,
  output logic       tx_tick,
  input  logic       rx_sync,
  input  logic       rx_busy,
  output logic       rx_tick
);

  import baud_controller_pkg::*;

  // Full bit period minus one, evaluated in 32 bits before narrowing
  function automatic logic [CNTW-1:0] full_target(input logic [1:0] div);
    return CNTW'(32'(SCALE) * div_mult(div) - 32'd1);
  endfunction

  // Half bit period (floored) minus one, for landing on the bit centre
  function automatic logic [CNTW-1:0] half_target(input logic [1:0] div);
    return CNTW'((32'(SCALE) * div_mult(div)) / 32'd2 - 32'd1);
  endfunction

  state_t          r_state;
  logic [1:0]      r_pend_div;
  logic            r_rx_half;
  logic            w_apply;
  logic            w_engines_active;
  logic [CNTW-1:0] w_tx_target;
  logic [CNTW-1:0] w_rx_target;

  assign w_apply          = (r_state == ST_APPLY);
  assign w_engines_active = tx_busy | rx_busy | rx_sync;
  assign w_tx_target      = full_target(cur_div);

  // rx aims for the bit centre first, then steps a full period at a time
  always_comb begin
    w_rx_target = full_target(cur_div);
    if (r_rx_half) begin
      w_rx_target = half_target(cur_div);
    end
  end

  // Config handshake: accept, wait for both engines idle, then swap divisor
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_pend_div  <= DIV_115200;
      cur_div     <= DIV_115200;
      cfg_ready   <= 1'b1;
      cfg_pending <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (cfg_valid) begin
            r_pend_div  <= cfg_div;
            cfg_ready   <= 1'b0;
            cfg_pending <= 1'b1;
            r_state     <= w_engines_active ? ST_PENDING : ST_APPLY;
          end
        end
        ST_PENDING: begin
          if (!w_engines_active) begin
            r_state <= ST_APPLY;
          end
        end
        ST_APPLY: begin
          cur_div     <= r_pend_div;
          cfg_ready   <= 1'b1;
          cfg_pending <= 1'b0;
          r_state     <= ST_IDLE;
        end
        default: begin
          r_state     <= ST_IDLE;
          cfg_ready   <= 1'b1;
          cfg_pending <= 1'b0;
        end
      endcase
    end
  end

  // Track whether the rx timer is still heading for the first bit centre
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rx_half <= 1'b0;
    end else if (rx_sync) begin
      r_rx_half <= 1'b1;
    end else if (w_apply || !rx_busy || rx_tick) begin
      r_rx_half <= 1'b0;
    end
  end

  baud_controller_bit_timer #(
    .CNTW (CNTW)
  ) u_tx_timer (
    .clock  (clock),
    .reset  (reset),
    .clear  (w_apply),
    .start  (1'b0),
    .enable (tx_busy),
    .target (w_tx_target),
    .tick   (tx_tick)
  );

  baud_controller_bit_timer #(
    .CNTW (CNTW)
  ) u_rx_timer (
    .clock  (clock),
    .reset  (reset),
    .clear  (w_apply),
    .start  (rx_sync),
    .enable (rx_busy),
    .target (w_rx_target),
    .tick   (rx_tick)
  );

endmodule : baud_controller
`default_nettype wire
